cpu_dma_arbiter: RTL and testbench

//  Sprite/page DMA engine and bus arbiter between the 6502 core and system memory.
//  A CPU write to TRIG_ADDR starts a copy of LEN bytes from {page, 8'h00} to the fixed port DEST_ADDR.
//  The block stalls the core through its ready input, takes ownership of the memory bus,
//  and hands the bus back to the core when the copy completes.
//  It sits between the core's address/data/write pins and the memory decoder.

---
 rtl/cpu_dma_arbiter.sv | 101 ++++++++++
 tb/tb_cpu_dma_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_dma_arbiter.sv
// Page DMA engine and core/DMA bus arbiter.
// Stalls the 6502 core while it copies a page to a fixed port.
module cpu_dma_arbiter #(
  parameter logic [15:0] TRIG_ADDR = 16'h4014,
  parameter logic [15:0] DEST_ADDR = 16'h2004,
  parameter int unsigned LEN       = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_address,
  input  logic        cpu_write,
  input  logic [7:0]  cpu_data_o,
  output logic [7:0]  cpu_data_i,
  output logic        cpu_ready,
  output logic [15:0] mem_address,
  output logic        mem_write,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        dma_busy
);

  typedef enum logic [1:0] {
    IDLE,
    HALT,
    READ,
    WRITE
  } state_t;

  // LEN=256 wraps to 8'hFF, so the source never leaves the page
  localparam logic [7:0] LAST_IDX = 8'(LEN - 1);

  state_t     state_q, state_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] page_q, page_d;
  logic [7:0] buf_q, buf_d;
  logic       trig;

  assign trig       = cpu_write && (cpu_address == TRIG_ADDR);
  assign cpu_data_i = mem_rdata;
  assign cpu_ready  = (state_q == IDLE);
  assign dma_busy   = (state_q != IDLE);

  // State and transfer registers; reset drops any transfer in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      page_q  <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      page_q  <= page_d;
      buf_q   <= buf_d;
    end
  end

  // Next state and bus mux: core owns the bus in IDLE/HALT, DMA otherwise
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    page_d      = page_q;
    buf_d       = buf_q;
    mem_address = cpu_address;
    mem_write   = cpu_write;
    mem_wdata   = cpu_data_o;
    unique case (state_q)
      IDLE: begin
        if (trig) begin
          page_d  = cpu_data_o;
          idx_d   = '0;
          state_d = HALT;
        end
      end
      HALT: begin
        // core writes cannot be stalled, wait for a read cycle
        if (!cpu_write) begin
          state_d = READ;
        end
      end
      READ: begin
        mem_address = {page_q, idx_q};
        mem_write   = 1'b0;
        buf_d       = mem_rdata;
        state_d     = WRITE;
      end
      WRITE: begin
        mem_address = DEST_ADDR;
        mem_write   = 1'b1;
        mem_wdata   = buf_q;
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = READ;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_dma_arbiter.sv
// Directed bench for cpu_dma_arbiter.
// Two instances: full-page (LEN=256) and short (LEN=4).
module tb_cpu_dma_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] a_addr, a_mem_address;
  logic        a_wr, a_cpu_ready, a_mem_write, a_dma_busy;
  logic [7:0]  a_wd, a_cpu_data_i, a_mem_wdata, a_mem_rdata;

  logic [15:0] b_addr, b_mem_address;
  logic        b_wr, b_cpu_ready, b_mem_write, b_dma_busy;
  logic [7:0]  b_wd, b_cpu_data_i, b_mem_wdata, b_mem_rdata;

  // source memory: distinct byte per address, page 2 holds i^5A
  function automatic logic [7:0] src(input logic [15:0] a);
    return a[7:0] ^ 8'h5A ^ (a[15:8] - 8'h02);
  endfunction

  assign a_mem_rdata = src(a_mem_address);
  assign b_mem_rdata = src(b_mem_address);

  cpu_dma_arbiter u_a (
    .clk(clk), .reset(reset),
    .cpu_address(a_addr), .cpu_write(a_wr),
    .cpu_data_o(a_wd), .cpu_data_i(a_cpu_data_i),
    .cpu_ready(a_cpu_ready), .mem_address(a_mem_address),
    .mem_write(a_mem_write), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata), .dma_busy(a_dma_busy)
  );

  cpu_dma_arbiter #(.LEN(4)) u_b (
    .clk(clk), .reset(reset),
    .cpu_address(b_addr), .cpu_write(b_wr),
    .cpu_data_o(b_wd), .cpu_data_i(b_cpu_data_i),
    .cpu_ready(b_cpu_ready), .mem_address(b_mem_address),
    .mem_write(b_mem_write), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .dma_busy(b_dma_busy)
  );

  logic [23:0] a_wlog[$];
  logic [7:0]  a_dlog[$];
  logic [7:0]  b_dlog[$];
  logic [15:0] b_rlog[$];
  int          a_stall = 0;
  int          b_stall = 0;

  // mid-cycle bus monitor
  always @(negedge clk) begin
    if (a_mem_write) a_wlog.push_back({a_mem_address, a_mem_wdata});
    if (a_dma_busy && a_mem_write && a_mem_address == 16'h2004)
      a_dlog.push_back(a_mem_wdata);
    if (!a_cpu_ready) a_stall++;
    if (b_dma_busy && b_mem_write && b_mem_address == 16'h2004)
      b_dlog.push_back(b_mem_wdata);
    if (b_dma_busy && !b_mem_write && b_mem_address != b_addr)
      b_rlog.push_back(b_mem_address);
    if (!b_cpu_ready) b_stall++;
  end

  int npass = 0;
  int ntotal = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_bus(input logic [15:0] ad, input logic w,
                       input logic [7:0] d);
    a_addr = ad;
    a_wr   = w;
    a_wd   = d;
  endtask

  task automatic b_bus(input logic [15:0] ad, input logic w,
                       input logic [7:0] d);
    b_addr = ad;
    b_wr   = w;
    b_wd   = d;
  endtask

  task automatic a_wait(output int k);
    k = 0;
    while (!a_cpu_ready && k < 2000) begin
      tick();
      k++;
    end
  endtask

  task automatic b_wait(output int k);
    k = 0;
    while (!b_cpu_ready && k < 200) begin
      tick();
      k++;
    end
  endtask

  task automatic a_dest(input string nm, input int s,
                        input logic [7:0] pg, input int n);
    int bad;
    bad = 0;
    chk({nm, "_cnt"}, 32'(a_dlog.size() - s), 32'(n));
    for (int i = 0; i < n && s + i < a_dlog.size(); i++)
      if (a_dlog[s+i] !== src({pg, 8'(i)})) bad++;
    chk({nm, "_data"}, 32'(bad), 32'd0);
  endtask

  function automatic logic has_w(input logic [15:0] ad,
                                 input logic [7:0] d, input int s);
    for (int i = s; i < a_wlog.size(); i++)
      if (a_wlog[i] == {ad, d}) return 1'b1;
    return 1'b0;
  endfunction

  typedef struct {
    logic [15:0] addr;
    logic        wr;
    logic [7:0]  data;
    logic        rdy;
    logic        busy;
    logic [15:0] maddr;
    logic        mwr;
    logic        chk_wd;
    logic [7:0]  wd;
  } vec_t;

  vec_t tv[11];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k, st, ds, ws, rs, n;

    // IDLE passthrough, trigger, HALT writes (incl. ignored retrigger),
    // then the first two DMA read/write pairs with the core bus ignored
    tv[0]  = '{16'h4015, 1'b1, 8'h33, 1'b1, 1'b0, 16'h4015, 1'b1, 1'b1, 8'h33};
    tv[1]  = '{16'h4014, 1'b0, 8'h00, 1'b1, 1'b0, 16'h4014, 1'b0, 1'b0, 8'h00};
    tv[2]  = '{16'h1234, 1'b1, 8'hA5, 1'b1, 1'b0, 16'h1234, 1'b1, 1'b1, 8'hA5};
    tv[3]  = '{16'h4014, 1'b1, 8'h02, 1'b1, 1'b0, 16'h4014, 1'b1, 1'b1, 8'h02};
    tv[4]  = '{16'h01FD, 1'b1, 8'h11, 1'b0, 1'b1, 16'h01FD, 1'b1, 1'b1, 8'h11};
    tv[5]  = '{16'h4014, 1'b1, 8'h07, 1'b0, 1'b1, 16'h4014, 1'b1, 1'b1, 8'h07};
    tv[6]  = '{16'h8000, 1'b0, 8'h00, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b0, 8'h00};
    tv[7]  = '{16'h1111, 1'b1, 8'h99, 1'b0, 1'b1, 16'h0200, 1'b0, 1'b0, 8'h00};
    tv[8]  = '{16'h1111, 1'b1, 8'h99, 1'b0, 1'b1, 16'h2004, 1'b1, 1'b1, 8'h5A};
    tv[9]  = '{16'h8000, 1'b0, 8'h00, 1'b0, 1'b1, 16'h0201, 1'b0, 1'b0, 8'h00};
    tv[10] = '{16'h8000, 1'b0, 8'h00, 1'b0, 1'b1, 16'h2004, 1'b1, 1'b1, 8'h5B};

    a_bus(16'h8000, 1'b0, 8'h00);
    b_bus(16'h8000, 1'b0, 8'h00);
    reset = 1'b1;
    repeat (3) tick();
    chk("rst_rdy_a", 32'(a_cpu_ready), 32'd1);
    chk("rst_busy_a", 32'(a_dma_busy), 32'd0);
    chk("rst_pass_a", 32'(a_mem_address), 32'h8000);
    chk("rst_rdy_b", 32'(b_cpu_ready), 32'd1);
    chk("rst_busy_b", 32'(b_dma_busy), 32'd0);
    reset = 1'b0;
    tick();

    st = a_stall;
    ds = a_dlog.size();
    ws = a_wlog.size();
    for (int i = 0; i < 11; i++) begin
      a_bus(tv[i].addr, tv[i].wr, tv[i].data);
      #1;
      chk($sformatf("v%0d_rdy", i), 32'(a_cpu_ready), 32'(tv[i].rdy));
      chk($sformatf("v%0d_busy", i), 32'(a_dma_busy), 32'(tv[i].busy));
      chk($sformatf("v%0d_addr", i), 32'(a_mem_address), 32'(tv[i].maddr));
      chk($sformatf("v%0d_wr", i), 32'(a_mem_write), 32'(tv[i].mwr));
      if (tv[i].chk_wd)
        chk($sformatf("v%0d_wd", i), 32'(a_mem_wdata), 32'(tv[i].wd));
      chk($sformatf("v%0d_rd", i), 32'(a_cpu_data_i),
          32'(src(tv[i].maddr)));
      tick();
    end
    a_bus(16'h8000, 1'b0, 8'h00);
    a_wait(k);
    chk("tbl_done", 32'(a_cpu_ready), 32'd1);
    chk("tbl_stall", 32'(a_stall - st), 32'd515);
    a_dest("tbl_dest", ds, 8'h02, 256);
    chk("halt_w1", 32'(has_w(16'h01FD, 8'h11, ws)), 32'd1);
    chk("halt_w2", 32'(has_w(16'h4014, 8'h07, ws)), 32'd1);
    chk("trig_w", 32'(has_w(16'h4014, 8'h02, ws)), 32'd1);

    // full page, no extra core writes
    st = a_stall;
    ds = a_dlog.size();
    ws = a_wlog.size();
    a_bus(16'h4014, 1'b1, 8'h02);
    tick();
    a_bus(16'h8000, 1'b0, 8'h00);
    a_wait(k);
    chk("t1_lat", 32'(k + 1), 32'd514);
    chk("t1_stall", 32'(a_stall - st), 32'd513);
    a_dest("t1", ds, 8'h02, 256);
    chk("t1_trig_w", 32'(has_w(16'h4014, 8'h02, ws)), 32'd1);

    // retrigger in the first IDLE cycle with a new page
    st = a_stall;
    ds = a_dlog.size();
    a_bus(16'h4014, 1'b1, 8'h03);
    tick();
    a_bus(16'h8000, 1'b0, 8'h00);
    a_wait(k);
    chk("t6_lat", 32'(k + 1), 32'd514);
    chk("t6_stall", 32'(a_stall - st), 32'd513);
    a_dest("t6", ds, 8'h03, 256);

    // reset during the WRITE of idx 10
    ds = a_dlog.size();
    a_bus(16'h4014, 1'b1, 8'h02);
    tick();
    a_bus(16'h8000, 1'b0, 8'h00);
    k = 0;
    while (!(a_dma_busy && a_mem_write && a_mem_address == 16'h2004 &&
             a_dlog.size() - ds == 10) && k < 100) begin
      tick();
      k++;
    end
    chk("t4_found", 32'(k < 100), 32'd1);
    chk("t4_rdy_before", 32'(a_cpu_ready), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t4_rdy", 32'(a_cpu_ready), 32'd1);
    chk("t4_busy", 32'(a_dma_busy), 32'd0);
    chk("t4_pass", 32'(a_mem_address), 32'h8000);
    repeat (20) tick();
    n = a_dlog.size() - ds;
    chk("t4_wcnt", 32'(n == 10 || n == 11), 32'd1);
    chk("t4_idle", 32'(a_dma_busy), 32'd0);

    // short transfer from the top page
    st = b_stall;
    ds = b_dlog.size();
    rs = b_rlog.size();
    b_bus(16'h4014, 1'b1, 8'hFF);
    tick();
    b_bus(16'h8000, 1'b0, 8'h00);
    b_wait(k);
    chk("t5_lat", 32'(k + 1), 32'd10);
    chk("t5_stall", 32'(b_stall - st), 32'd9);
    chk("t5_wcnt", 32'(b_dlog.size() - ds), 32'd4);
    chk("t5_rcnt", 32'(b_rlog.size() - rs), 32'd4);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (ds + i < b_dlog.size() &&
          b_dlog[ds+i] !== src({8'hFF, 8'(i)})) n++;
      if (rs + i < b_rlog.size() &&
          b_rlog[rs+i] !== {8'hFF, 8'(i)}) n++;
    end
    chk("t5_data", 32'(n), 32'd0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
